// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-port arbiter:
// operation codes, FSM state encoding and the control-code legality check.
package alu_pkg;

  localparam int unsigned ALU_DATA_W = 32;
  localparam int unsigned ALU_CTRL_W = 5;
  localparam int unsigned ALU_CNT_W  = 16;

  // Control codes understood by the ALU
  localparam int unsigned ALU_AND = 0;
  localparam int unsigned ALU_OR  = 1;
  localparam int unsigned ALU_ADD = 2;
  localparam int unsigned ALU_SUB = 6;
  localparam int unsigned ALU_SLT = 7;
  localparam int unsigned ALU_NOR = 12;
  localparam int unsigned ALU_MUL = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // True when the code names an operation the ALU implements
  function automatic logic alu_ctrl_legal(input int unsigned code);
    case (code)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_SLT, ALU_NOR, ALU_MUL: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational ALU. Unknown control codes yield a zero result and raise err.
module alu_share_arbiter_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned CTRL_W = ALU_CTRL_W
) (
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              err
);

  int unsigned code;

  assign code = 32'(ctrl);

  // Evaluate the selected operation; SLT is an unsigned compare
  always_comb begin
    result = '0;
    case (code)
      ALU_AND: result = src1 & src2;
      ALU_OR:  result = src1 | src2;
      ALU_ADD: result = src1 + src2;
      ALU_SUB: result = src1 - src2;
      ALU_SLT: result = (src1 < src2) ? DATA_W'(1) : '0;
      ALU_NOR: result = ~(src1 | src2);
      ALU_MUL: result = src1 * src2;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign err  = ~alu_ctrl_legal(code);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin front end for a single shared ALU.
//
// Handshake rules: on each request port a transfer happens on the rising edge
// where valid and ready are both 1. Ready is a one-cycle accept pulse raised
// only in IDLE and only for the granted port; the block samples ctrl/operands
// on that edge alone, so requesters hold them stable while valid is high and
// ready is low. The response channel transfers on the edge where rsp_valid_o
// and rsp_ready_i are both 1; rsp_* outputs stay stable until then.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = ALU_DATA_W,
  parameter int unsigned CTRL_W = ALU_CTRL_W,
  parameter int unsigned CNT_W  = ALU_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  input  logic [DATA_W-1:0] req0_src1_i,
  input  logic [DATA_W-1:0] req0_src2_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  input  logic [DATA_W-1:0] req1_src1_i,
  input  logic [DATA_W-1:0] req1_src2_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_err_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  ops_done_o,
  output state_t            dbg_state_o
);

  state_t            state_q;
  logic              ptr_q;
  logic [CTRL_W-1:0] cap_ctrl_q;
  logic [DATA_W-1:0] cap_src1_q;
  logic [DATA_W-1:0] cap_src2_q;
  logic              cap_id_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic              rsp_zero_q;
  logic              rsp_err_q;
  logic [CNT_W-1:0]  ops_done_q;

  logic              any_valid;
  logic              grant_id;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              alu_err;

  // Choose the requester to serve: a lone valid wins, the pointer breaks ties
  always_comb begin
    any_valid = req0_valid_i | req1_valid_i;
    grant_id  = 1'b0;
    if (req0_valid_i && req1_valid_i) begin
      grant_id = ptr_q;
    end else if (req1_valid_i) begin
      grant_id = 1'b1;
    end
  end

  // Accept pulses: raised only in IDLE and only for the granted requester
  always_comb begin
    req0_ready_o = 1'b0;
    req1_ready_o = 1'b0;
    if (state_q == IDLE && any_valid) begin
      req0_ready_o = ~grant_id;
      req1_ready_o = grant_id;
    end
  end

  alu_share_arbiter_alu #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W)
  ) u_alu (
    .ctrl   (cap_ctrl_q),
    .src1   (cap_src1_q),
    .src2   (cap_src2_q),
    .result (alu_result),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  // Grant/capture, execute, then hold the response until it is taken
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      cap_ctrl_q   <= '0;
      cap_src1_q   <= '0;
      cap_src2_q   <= '0;
      cap_id_q     <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b1;
      rsp_err_q    <= 1'b0;
      ops_done_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            cap_ctrl_q <= grant_id ? req1_ctrl_i : req0_ctrl_i;
            cap_src1_q <= grant_id ? req1_src1_i : req0_src1_i;
            cap_src2_q <= grant_id ? req1_src2_i : req0_src2_i;
            cap_id_q   <= grant_id;
            state_q    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          rsp_err_q    <= alu_err;
          rsp_id_q     <= cap_id_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            ops_done_q <= ops_done_q + CNT_W'(1);
            // Favour the requester that was not just served
            ptr_q      <= ~rsp_id_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o  = (state_q == RESP);
  assign busy_o       = (state_q != IDLE);
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign rsp_err_o    = rsp_err_q;
  assign ops_done_o   = ops_done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: vector table of single operations,
// plus round-robin, backpressure and mid-operation reset sequences.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 5;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
  logic [DATA_W-1:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic              rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [DATA_W-1:0] rsp_result;
  logic [CNT_W-1:0]  ops_done;
  state_t            dbg_state;

  alu_share_arbiter #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .req0_valid_i (req0_valid),
    .req0_ready_o (req0_ready),
    .req0_ctrl_i  (req0_ctrl),
    .req0_src1_i  (req0_src1),
    .req0_src2_i  (req0_src2),
    .req1_valid_i (req1_valid),
    .req1_ready_o (req1_ready),
    .req1_ctrl_i  (req1_ctrl),
    .req1_src1_i  (req1_src1),
    .req1_src2_i  (req1_src2),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_id_o     (rsp_id),
    .rsp_result_o (rsp_result),
    .rsp_zero_o   (rsp_zero),
    .rsp_err_o    (rsp_err),
    .busy_o       (busy),
    .ops_done_o   (ops_done),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  int exp_done = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_rsp_result(input string name);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: response with empty expected queue, got 0x%0h", name, rsp_result);
    end else begin
      check(name, rsp_result, exp_q.pop_front());
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    req0_valid = 1'b0; req0_ctrl = '0; req0_src1 = '0; req0_src2 = '0;
    req1_valid = 1'b0; req1_ctrl = '0; req1_src1 = '0; req1_src2 = '0;
  endtask

  task automatic drive_req(input bit port, input logic [CTRL_W-1:0] ctrl,
                           input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    if (!port) begin
      req0_valid = 1'b1; req0_ctrl = ctrl; req0_src1 = a; req0_src2 = b;
    end else begin
      req1_valid = 1'b1; req1_ctrl = ctrl; req1_src1 = a; req1_src2 = b;
    end
  endtask

  task automatic drop_req(input bit port);
    if (!port) req0_valid = 1'b0;
    else       req1_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_done = 0;
    exp_q.delete();
  endtask

  // Returns at the falling edge of the cycle in which the port sees ready
  task automatic wait_grant(input bit port, input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (port ? req1_ready : req0_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no grant within 20 cycles", name);
    end
  endtask

  // One operation end to end, checking the T / T+1 / T+2 timeline
  task automatic run_op(input string name, input bit port, input logic [CTRL_W-1:0] ctrl,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [DATA_W-1:0] er, input logic ez, input logic ee);
    bit ok;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drive_req(port, ctrl, a, b);
    exp_q.push_back(er);
    wait_grant(port, {name, "_grant"}, ok);
    if (ok) begin
      check1({name, "_other_ready"}, port ? req0_ready : req1_ready, 1'b0);
      @(posedge clk); #1;
      drop_req(port);
      @(negedge clk);
      check1({name, "_valid_t1"}, rsp_valid, 1'b0);
      check1({name, "_busy_t1"}, busy, 1'b1);
      @(negedge clk);
      check1({name, "_valid_t2"}, rsp_valid, 1'b1);
      check1({name, "_id"}, rsp_id, port);
      check_rsp_result({name, "_result"});
      check1({name, "_zero"}, rsp_zero, ez);
      check1({name, "_err"}, rsp_err, ee);
      @(posedge clk); #1;
      exp_done++;
      @(negedge clk);
      check({name, "_ops_done"}, DATA_W'(ops_done), DATA_W'(exp_done));
      check({name, "_state_idle"}, DATA_W'(dbg_state), DATA_W'(IDLE));
    end else begin
      drop_req(port);
      void'(exp_q.pop_front());
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit                port;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] er;
    logic              ez;
    logic              ee;
  } vec_t;

  vec_t vecs[14];

  initial begin
    bit ok;
    int grants, resps, last_g, bad;

    vecs[0]  = '{1'b0, CTRL_W'(ALU_ADD), 32'd7,          32'd5,     32'd12,         1'b0, 1'b0};
    vecs[1]  = '{1'b1, CTRL_W'(ALU_SUB), 32'd5,          32'd5,     32'd0,          1'b1, 1'b0};
    vecs[2]  = '{1'b0, CTRL_W'(ALU_ADD), 32'hFFFF_FFFF,  32'd1,     32'd0,          1'b1, 1'b0};
    vecs[3]  = '{1'b1, CTRL_W'(ALU_SLT), 32'h8000_0000,  32'd1,     32'd0,          1'b1, 1'b0};
    vecs[4]  = '{1'b0, CTRL_W'(ALU_MUL), 32'h0001_0000,  32'h1_0000, 32'd0,         1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'd3,             32'd12,         32'd34,    32'd0,          1'b1, 1'b1};
    vecs[6]  = '{1'b0, CTRL_W'(ALU_AND), 32'h0000_F0F0,  32'hFF00,  32'h0000_F000,  1'b0, 1'b0};
    vecs[7]  = '{1'b1, CTRL_W'(ALU_OR),  32'h0000_000F,  32'hF0,    32'h0000_00FF,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, CTRL_W'(ALU_NOR), 32'd0,          32'd0,     32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[9]  = '{1'b1, CTRL_W'(ALU_SLT), 32'd1,          32'd2,     32'd1,          1'b0, 1'b0};
    vecs[10] = '{1'b0, CTRL_W'(ALU_SUB), 32'd3,          32'd5,     32'hFFFF_FFFE,  1'b0, 1'b0};
    vecs[11] = '{1'b1, CTRL_W'(ALU_MUL), 32'h1234,       32'h10,    32'h0001_2340,  1'b0, 1'b0};
    vecs[12] = '{1'b0, 5'd31,            32'd1,          32'd1,     32'd0,          1'b1, 1'b1};
    vecs[13] = '{1'b1, CTRL_W'(ALU_SLT), 32'd7,          32'd7,     32'd0,          1'b1, 1'b0};

    rst = 1'b0;
    rsp_ready = 1'b1;
    idle_inputs();

    // ---- reset values ----
    repeat (2) @(posedge clk);
    @(negedge clk);
    check1("rst_ready0", req0_ready, 1'b0);
    check1("rst_ready1", req1_ready, 1'b0);
    check1("rst_rsp_valid", rsp_valid, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_id", rsp_id, 1'b0);
    check("rst_result", rsp_result, '0);
    check1("rst_zero", rsp_zero, 1'b1);
    check1("rst_err", rsp_err, 1'b0);
    check("rst_ops_done", DATA_W'(ops_done), '0);
    check("rst_state", DATA_W'(dbg_state), DATA_W'(IDLE));
    @(posedge clk); #1;
    rst = 1'b1;

    // ---- table of single operations ----
    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].port, vecs[i].ctrl, vecs[i].a, vecs[i].b,
             vecs[i].er, vecs[i].ez, vecs[i].ee);
    end

    // ---- round robin with both requesters always valid ----
    apply_reset();
    @(posedge clk); #1;
    drive_req(1'b0, CTRL_W'(ALU_ADD), 32'd1, 32'd1);
    drive_req(1'b1, CTRL_W'(ALU_ADD), 32'd2, 32'd2);
    grants = 0;
    resps  = 0;
    last_g = 0;
    for (int c = 0; c < 60 && resps < 6; c++) begin
      @(negedge clk);
      check1("rr_one_ready", req0_ready & req1_ready, 1'b0);
      if (req0_ready || req1_ready) begin
        check1($sformatf("rr_grant%0d_id", grants), req1_ready, 1'(grants % 2));
        if (grants > 0) check($sformatf("rr_spacing%0d", grants), DATA_W'(c - last_g), 32'd3);
        last_g = c;
        exp_q.push_back(req1_ready ? 32'd4 : 32'd2);
        grants++;
      end
      if (rsp_valid && rsp_ready) begin
        check_rsp_result($sformatf("rr_result%0d", resps));
        resps++;
      end
      @(posedge clk); #1;
      if (grants >= 6) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    check("rr_responses", DATA_W'(resps), 32'd6);
    @(negedge clk);
    check("rr_ops_done", DATA_W'(ops_done), 32'd6);
    exp_done = 6;

    // ---- backpressure: response held, port 1 kept waiting ----
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    drive_req(1'b0, CTRL_W'(ALU_OR), 32'h0000_00A0, 32'h0000_000B);
    wait_grant(1'b0, "bp_grant0", ok);
    @(posedge clk); #1;
    drop_req(1'b0);
    @(negedge clk);
    @(negedge clk);
    check1("bp_valid_t2", rsp_valid, 1'b1);
    @(posedge clk); #1;
    drive_req(1'b1, CTRL_W'(ALU_SUB), 32'd9, 32'd4);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check1($sformatf("bp_hold_valid%0d", i), rsp_valid, 1'b1);
      check($sformatf("bp_hold_result%0d", i), rsp_result, 32'h0000_00AB);
      check1($sformatf("bp_hold_id%0d", i), rsp_id, 1'b0);
      check1($sformatf("bp_hold_ready1_%0d", i), req1_ready, 1'b0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check1("bp_release_ready1", req1_ready, 1'b0);
    check("bp_release_state", DATA_W'(dbg_state), DATA_W'(RESP));
    @(negedge clk);
    exp_done++;
    check1("bp_grant1_next_idle", req1_ready, 1'b1);
    check("bp_ops_done", DATA_W'(ops_done), DATA_W'(exp_done));
    @(posedge clk); #1;
    drop_req(1'b1);
    @(negedge clk);
    @(negedge clk);
    check1("bp_rsp1_valid", rsp_valid, 1'b1);
    check1("bp_rsp1_id", rsp_id, 1'b1);
    check("bp_rsp1_result", rsp_result, 32'd5);
    @(posedge clk); #1;
    exp_done++;

    // ---- reset during EXEC discards the operation ----
    run_op("pre_rst", 1'b0, CTRL_W'(ALU_ADD), 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_req(1'b1, CTRL_W'(ALU_ADD), 32'd10, 32'd20);
    wait_grant(1'b1, "mid_grant", ok);
    @(posedge clk); #1;
    drop_req(1'b1);
    @(negedge clk);
    check("mid_state_exec", DATA_W'(dbg_state), DATA_W'(EXEC));
    rst = 1'b0;
    @(negedge clk);
    check1("mid_rst_ready0", req0_ready, 1'b0);
    check1("mid_rst_ready1", req1_ready, 1'b0);
    check1("mid_rst_valid", rsp_valid, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    check1("mid_rst_id", rsp_id, 1'b0);
    check("mid_rst_result", rsp_result, '0);
    check1("mid_rst_zero", rsp_zero, 1'b1);
    check1("mid_rst_err", rsp_err, 1'b0);
    check("mid_rst_ops_done", DATA_W'(ops_done), '0);
    check("mid_rst_state", DATA_W'(dbg_state), DATA_W'(IDLE));
    @(posedge clk); #1;
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad++;
    end
    check("mid_no_response", DATA_W'(bad), '0);
    // Port 0 was served last, so only a cleared pointer grants port 0 here
    @(posedge clk); #1;
    drive_req(1'b0, CTRL_W'(ALU_ADD), 32'd1, 32'd1);
    drive_req(1'b1, CTRL_W'(ALU_ADD), 32'd2, 32'd2);
    @(negedge clk);
    check1("mid_ptr_ready0", req0_ready, 1'b1);
    check1("mid_ptr_ready1", req1_ready, 1'b0);
    @(posedge clk); #1;
    idle_inputs();

    // ---- final report ----
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
